// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } lsu_state_t;

    // Size 3 has no legal encoding and is rejected like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = lane[0];
            SIZE_W:  mis = (lane != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Lane extraction with sign/zero extension for loads; the lane mask output
// is shared with the store path to merge sub-word writes.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data,
    output logic [31:0] lane_mask
);

    logic [31:0] shifted;
    logic [4:0]  shamt;

    assign shamt = {lane, 3'b000};

    always_comb begin
        shifted   = word >> shamt;
        data      = word;
        lane_mask = 32'hFFFF_FFFF;
        case (size)
            SIZE_B: begin
                data      = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
                lane_mask = 32'h0000_00FF << shamt;
            end
            SIZE_H: begin
                data      = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
                lane_mask = 32'h0000_FFFF << shamt;
            end
            default: begin
                data      = word;
                lane_mask = 32'hFFFF_FFFF;
            end
        endcase
    end

endmodule

// File: rtl/lsu_data_port.sv
// Load/store unit driving the word-only data port of the dual-port ram.
// Sub-word stores are read-modify-write; misaligned requests never touch memory.
module lsu_data_port
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic                  mem_wEn,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    lsu_state_t state_q, state_d;

    logic [ADDR_WIDTH+1:0] addr_q;
    logic [1:0]            size_q;
    logic                  write_q;
    logic                  unsigned_q;
    logic [31:0]           wdata_q;
    logic [31:0]           wbuf_q;

    logic        resp_valid_d, resp_error_d;
    logic [31:0] resp_rdata_d;

    logic        accept, req_mis, word_store;
    logic [31:0] aligned, lane_mask, merged;

    // Upper address bits are deliberately dropped so addresses wrap.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

    assign accept     = req_valid && (state_q == IDLE);
    assign req_mis    = is_misaligned(req_size, req_addr[1:0]);
    assign word_store = req_write && (req_size == SIZE_W);

    lsu_load_align u_align (
        .word        (mem_read_data),
        .lane        (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .data        (aligned),
        .lane_mask   (lane_mask)
    );

    assign merged = (mem_read_data & ~lane_mask)
                  | ((wdata_q << {addr_q[1:0], 3'b000}) & lane_mask);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && !req_mis) begin
                    state_d = word_store ? WR : RD;
                end
            end
            RD:  state_d = CAP;
            CAP: state_d = write_q ? WR : IDLE;
            WR:  state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = (state_q == IDLE);
        mem_wEn        = (state_q == WR);
        mem_address    = addr_q[ADDR_WIDTH+1:2];
        mem_write_data = wbuf_q;
        resp_valid_d   = 1'b0;
        resp_error_d   = 1'b0;
        resp_rdata_d   = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (accept && req_mis) begin
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                end
            end
            RD: ;
            CAP: begin
                if (!write_q) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = aligned;
                end
            end
            WR: resp_valid_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            size_q     <= SIZE_B;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= 32'h0;
            wbuf_q     <= 32'h0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            if (accept) begin
                addr_q     <= req_addr[ADDR_WIDTH+1:0];
                size_q     <= req_size;
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                wdata_q    <= req_wdata;
                if (word_store && !req_mis) begin
                    wbuf_q <= req_wdata;
                end
            end
            if (state_q == CAP && write_q) begin
                wbuf_q <= merged;
            end
            resp_valid <= resp_valid_d;
            resp_error <= resp_error_d;
            resp_rdata <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_data_port.sv
// Self-checking bench for lsu_data_port: directed scenarios plus random traffic
// compared against a byte-level memory model.
module tb_lsu_data_port;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_wEn;
    logic [15:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ram [0:65535];
    logic [31:0] model_mem [0:15];

    lsu_data_port #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_wEn        (mem_wEn),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural ram data port: synchronous read, write on wEn.
    always @(posedge clock) begin
        if (mem_wEn) ram[mem_address] <= mem_write_data;
        mem_read_data <= ram[mem_address];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where resp_valid was seen.
    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int waited);
        int          idx, lane, exp_lat, exp_wcyc, lat, wcyc, wcount, nbytes;
        logic        mis, got;
        logic [31:0] old, nw, v;

        rd     = 32'h0;
        waited = 0;
        while (!req_ready && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        if (!req_ready) begin
            check_val({tag, ":ready_wait"}, 32'(req_ready), 32'd1);
            return;
        end

        idx  = int'(addr[17:2]);
        lane = int'(addr[1:0]);
        mis  = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && lane != 0);
        old  = model_mem[idx];
        nw   = old;
        v    = 32'h0;
        if (mis) begin
            exp_lat  = 1;
            exp_wcyc = 0;
        end else if (wr) begin
            nbytes = 1 << sz;
            for (int b = 0; b < nbytes; b++) nw[8*(lane+b) +: 8] = wd[8*b +: 8];
            exp_lat  = (sz == 2'd2) ? 2 : 4;
            exp_wcyc = (sz == 2'd2) ? 1 : 3;
        end else begin
            v = old >> (8 * lane);
            if (sz == 2'd0) v = uns ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            if (sz == 2'd1) v = uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            exp_lat  = 3;
            exp_wcyc = 0;
        end

        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        got    = 1'b0;
        lat    = 0;
        wcyc   = 0;
        wcount = 0;
        for (int k = 1; k <= 6 && !got; k++) begin
            @(negedge clock);
            if (k == 1) req_valid = 1'b0;
            if (mem_wEn) begin
                wcount++;
                wcyc = k;
                check_val({tag, ":waddr"}, {16'h0, mem_address}, 32'(idx));
            end
            if (resp_valid) begin
                got = 1'b1;
                lat = k;
                rd  = resp_rdata;
                check_val({tag, ":rdata"}, resp_rdata, v);
                check_val({tag, ":error"}, 32'(resp_error), 32'(mis));
                check_val({tag, ":ready"}, 32'(req_ready), 32'd1);
            end
        end
        check_val({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, ":wcount"}, 32'(wcount), (exp_wcyc != 0) ? 32'd1 : 32'd0);
        check_val({tag, ":wcycle"}, 32'(wcyc), 32'(exp_wcyc));
        if (wr && !mis) begin
            model_mem[idx] = nw;
            check_val({tag, ":memword"}, ram[idx], nw);
        end
    endtask

    task automatic check_all_mem(input string tag);
        for (int i = 0; i < 16; i++) check_val(tag, ram[i], model_mem[i]);
    endtask

    initial begin
        logic [31:0] rd;
        int          waited, cnt;
        logic [31:0] a, w;
        logic [1:0]  sz;

        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        repeat (2) @(negedge clock);
        check_val("rst:ready", 32'(req_ready), 32'd1);
        check_val("rst:resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst:resp_rdata", resp_rdata, 32'h0);
        check_val("rst:resp_error", 32'(resp_error), 32'd0);
        check_val("rst:wen", 32'(mem_wEn), 32'd0);
        check_val("rst:maddr", {16'h0, mem_address}, 32'h0);
        check_val("rst:mwdata", mem_write_data, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        // Preload words 0..15 through the DUT; word 1 gets the known pattern.
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 32'h0;
            w = (i == 1) ? 32'h8765_43A1 : $urandom;
            do_req("init_sw", 1'b1, 2'd2, 1'b0, 32'(i * 4), w, rd, waited);
        end

        do_req("lb4", 1'b0, 2'd0, 1'b0, 32'h4, 32'h0, rd, waited);
        check_val("lb4:const", rd, 32'hFFFF_FFA1);
        do_req("lbu4", 1'b0, 2'd0, 1'b1, 32'h4, 32'h0, rd, waited);
        check_val("lbu4:const", rd, 32'h0000_00A1);
        do_req("lb5", 1'b0, 2'd0, 1'b0, 32'h5, 32'h0, rd, waited);
        check_val("lb5:const", rd, 32'h0000_0043);
        do_req("lh6", 1'b0, 2'd1, 1'b0, 32'h6, 32'h0, rd, waited);
        check_val("lh6:const", rd, 32'hFFFF_8765);
        do_req("lhu6", 1'b0, 2'd1, 1'b1, 32'h6, 32'h0, rd, waited);
        check_val("lhu6:const", rd, 32'h0000_8765);
        do_req("lw4", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, waited);
        check_val("lw4:const", rd, 32'h8765_43A1);

        do_req("sb7", 1'b1, 2'd0, 1'b0, 32'h7, 32'h0000_00CC, rd, waited);
        check_val("sb7:word1", ram[1], 32'hCC65_43A1);

        do_req("sw8", 1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF, rd, waited);
        do_req("lw8", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd, waited);
        check_val("lw8:const", rd, 32'hDEAD_BEEF);
        check_val("lw8:no_idle", 32'(waited), 32'd0);

        do_req("lw6_mis", 1'b0, 2'd2, 1'b0, 32'h6, 32'h0, rd, waited);
        do_req("sh3_mis", 1'b1, 2'd1, 1'b0, 32'h3, 32'h1234_5678, rd, waited);
        do_req("sz3_mis", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, rd, waited);
        check_all_mem("mis:mem");

        // sh 0x4 aborted by reset during CAP.
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_size     = 2'd1;
        req_unsigned = 1'b0;
        req_addr     = 32'h4;
        req_wdata    = 32'h0000_5A5A;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_val("abort:wen", 32'(mem_wEn), 32'd0);
        check_val("abort:ready", 32'(req_ready), 32'd1);
        check_val("abort:resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (mem_wEn || resp_valid) cnt++;
        end
        check_val("abort:late_activity", 32'(cnt), 32'd0);
        check_val("abort:word1", ram[1], model_mem[1]);

        // Random traffic over words 0..15, sometimes with wrapping upper address bits.
        for (int n = 0; n < 300; n++) begin
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom << 18);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_req("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                   rd, waited);
        end
        check_all_mem("final:mem");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
